// File: rtl/dct_block_scheduler.sv
// Walks a frame of DCT blocks in raster order: starts the engine per block,
// waits for completion with a timeout, then hands coordinates to the quantizer.
module dct_block_scheduler #(
  parameter int BLOCK_SIZE = 8,
  parameter int COORD_W    = 8,
  parameter int TIMEOUT    = 256
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   frame_start,
  input  logic                                   abort,
  input  logic [COORD_W-1:0]                     cfg_blocks_x,
  input  logic [COORD_W-1:0]                     cfg_blocks_y,
  output logic                                   dct_start,
  input  logic                                   dct_done,
  output logic [COORD_W-1:0]                     blk_x,
  output logic [COORD_W-1:0]                     blk_y,
  output logic [COORD_W+$clog2(BLOCK_SIZE)-1:0]  pix_x,
  output logic [COORD_W+$clog2(BLOCK_SIZE)-1:0]  pix_y,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   out_last,
  output logic                                   busy,
  output logic                                   frame_done,
  output logic                                   err
);

  localparam int SHIFT = $clog2(BLOCK_SIZE);
  localparam int PIX_W = COORD_W + SHIFT;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_EMIT,
    S_ERROR
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [COORD_W-1:0] cfg_x_q;
  logic [COORD_W-1:0] cfg_y_q;
  logic [CNT_W-1:0]   wait_cnt;
  logic               accept;
  logic               handshake;
  logic               row_end;
  logic               at_last;
  logic               timed_out;

  assign accept    = (state_q == S_IDLE) && frame_start &&
                     (cfg_blocks_x != '0) && (cfg_blocks_y != '0);
  assign handshake = (state_q == S_EMIT) && out_ready;
  assign row_end   = (blk_x == cfg_x_q - COORD_W'(1));
  assign at_last   = row_end && (blk_y == cfg_y_q - COORD_W'(1));
  assign timed_out = (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // abort outranks every other input; dct_done wins over a coincident timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (dct_done)       state_d = S_EMIT;
        else if (timed_out) state_d = S_ERROR;
      end
      S_EMIT:  if (handshake) state_d = at_last ? S_IDLE : S_ISSUE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  always_comb begin
    dct_start = (state_q == S_ISSUE);
    out_valid = (state_q == S_EMIT);
    out_last  = (state_q == S_EMIT) && at_last;
    err       = (state_q == S_ERROR);
    busy      = (state_q != S_IDLE);
  end

  assign pix_x = PIX_W'(blk_x) << SHIFT;
  assign pix_y = PIX_W'(blk_y) << SHIFT;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cfg_x_q    <= '0;
      cfg_y_q    <= '0;
      blk_x      <= '0;
      blk_y      <= '0;
      wait_cnt   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= handshake && at_last && !abort;
      if (accept && !abort) begin
        cfg_x_q <= cfg_blocks_x;
        cfg_y_q <= cfg_blocks_y;
        blk_x   <= '0;
        blk_y   <= '0;
      end else if (handshake && !at_last && !abort) begin
        if (row_end) begin
          blk_x <= '0;
          blk_y <= blk_y + COORD_W'(1);
        end else begin
          blk_x <= blk_x + COORD_W'(1);
        end
      end
      if (state_q == S_WAIT) wait_cnt <= wait_cnt + CNT_W'(1);
      else                   wait_cnt <= '0;
    end
  end

endmodule
